// File: rtl/bbox_seek.sv
// Frame-level bounding-box finder: tracks min/max column/row and hit count of foreground
// pixels in a raster stream, publishing a held result with a validity verdict at frame end.
module bbox_seek #(
  parameter int unsigned IMG_W    = 1024,
  parameter int unsigned IMG_H    = 755,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned THRESH   = 0,
  parameter int unsigned MIN_HITS = 16,
  parameter int unsigned CNT_W    = 11,
  parameter int unsigned HIT_W    = 20
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] pi_data,
  input  logic              pi_flag,
  input  logic              pi_sof,
  output logic [CNT_W-1:0]  x_min,
  output logic [CNT_W-1:0]  x_max,
  output logic [CNT_W-1:0]  y_min,
  output logic [CNT_W-1:0]  y_max,
  output logic [HIT_W-1:0]  hit_cnt,
  output logic              box_valid,
  output logic              po_flag,
  output logic              frame_err
);

  localparam logic [CNT_W-1:0]  ColLast = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0]  RowLast = CNT_W'(IMG_H - 1);
  localparam logic [HIT_W-1:0]  HitMax  = '1;
  localparam logic [HIT_W-1:0]  MinHits = HIT_W'(MIN_HITS);
  localparam logic [DATA_W-1:0] Thresh  = DATA_W'(THRESH);

  typedef enum logic [0:0] {StWaitSof, StActive} state_e;

  state_e             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_col, w_col_nxt, r_row, w_row_nxt;
  logic [CNT_W-1:0]   r_wx_min, w_wx_min_nxt, r_wx_max, w_wx_max_nxt;
  logic [CNT_W-1:0]   r_wy_min, w_wy_min_nxt, r_wy_max, w_wy_max_nxt;
  logic [HIT_W-1:0]   r_whits, w_whits_nxt;
  logic [CNT_W-1:0]   r_x_min, w_x_min_nxt, r_x_max, w_x_max_nxt;
  logic [CNT_W-1:0]   r_y_min, w_y_min_nxt, r_y_max, w_y_max_nxt;
  logic [HIT_W-1:0]   r_hit_cnt, w_hit_cnt_nxt;
  logic               r_box_valid, w_box_valid_nxt;
  logic               r_po_flag, w_po_flag_nxt, r_frame_err, w_frame_err_nxt;

  logic               w_restart, w_accept, w_fg, w_last, w_err, w_valid;
  logic [CNT_W-1:0]   w_col, w_row;
  logic [CNT_W-1:0]   w_bx_min, w_bx_max, w_by_min, w_by_max;
  logic [CNT_W-1:0]   w_ax_min, w_ax_max, w_ay_min, w_ay_max;
  logic [HIT_W-1:0]   w_bhits, w_ahits;

  always_comb begin
    // A qualified SOF always restarts at (0,0) on seeded accumulators, from either state.
    w_restart = pi_flag & pi_sof;
    w_accept  = pi_flag & (w_restart | (r_state == StActive));
    w_col     = w_restart ? '0 : r_col;
    w_row     = w_restart ? '0 : r_row;
    w_fg      = pi_data > Thresh;
    w_bx_min  = w_restart ? ColLast : r_wx_min;
    w_bx_max  = w_restart ? '0      : r_wx_max;
    w_by_min  = w_restart ? RowLast : r_wy_min;
    w_by_max  = w_restart ? '0      : r_wy_max;
    w_bhits   = w_restart ? '0      : r_whits;

    w_ax_min  = (w_fg && (w_col < w_bx_min)) ? w_col : w_bx_min;
    w_ax_max  = (w_fg && (w_col > w_bx_max)) ? w_col : w_bx_max;
    w_ay_min  = (w_fg && (w_row < w_by_min)) ? w_row : w_by_min;
    w_ay_max  = (w_fg && (w_row > w_by_max)) ? w_row : w_by_max;
    w_ahits   = (w_fg && (w_bhits != HitMax)) ? w_bhits + HIT_W'(1) : w_bhits;

    w_last    = w_accept & ~w_restart & (r_col == ColLast) & (r_row == RowLast);
    w_err     = w_restart & (r_state == StActive) & ((r_col != '0) | (r_row != '0));
    w_valid   = w_ahits >= MinHits;

    w_state_nxt     = r_state;
    w_col_nxt       = r_col;
    w_row_nxt       = r_row;
    w_wx_min_nxt    = r_wx_min;
    w_wx_max_nxt    = r_wx_max;
    w_wy_min_nxt    = r_wy_min;
    w_wy_max_nxt    = r_wy_max;
    w_whits_nxt     = r_whits;
    w_x_min_nxt     = r_x_min;
    w_x_max_nxt     = r_x_max;
    w_y_min_nxt     = r_y_min;
    w_y_max_nxt     = r_y_max;
    w_hit_cnt_nxt   = r_hit_cnt;
    w_box_valid_nxt = r_box_valid;
    w_po_flag_nxt   = 1'b0;
    w_frame_err_nxt = 1'b0;

    if (w_accept) begin
      if (w_last) begin
        w_state_nxt     = StWaitSof;
        w_col_nxt       = '0;
        w_row_nxt       = '0;
        w_wx_min_nxt    = ColLast;
        w_wx_max_nxt    = '0;
        w_wy_min_nxt    = RowLast;
        w_wy_max_nxt    = '0;
        w_whits_nxt     = '0;
        w_x_min_nxt     = w_valid ? w_ax_min : '0;
        w_x_max_nxt     = w_valid ? w_ax_max : '0;
        w_y_min_nxt     = w_valid ? w_ay_min : '0;
        w_y_max_nxt     = w_valid ? w_ay_max : '0;
        w_hit_cnt_nxt   = w_ahits;
        w_box_valid_nxt = w_valid;
        w_po_flag_nxt   = 1'b1;
      end else begin
        w_state_nxt     = StActive;
        w_wx_min_nxt    = w_ax_min;
        w_wx_max_nxt    = w_ax_max;
        w_wy_min_nxt    = w_ay_min;
        w_wy_max_nxt    = w_ay_max;
        w_whits_nxt     = w_ahits;
        w_frame_err_nxt = w_err;
        if (w_col == ColLast) begin
          w_col_nxt = '0;
          w_row_nxt = w_row + CNT_W'(1);
        end else begin
          w_col_nxt = w_col + CNT_W'(1);
          w_row_nxt = w_row;
        end
      end
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StWaitSof;
      r_col       <= '0;
      r_row       <= '0;
      r_wx_min    <= ColLast;
      r_wx_max    <= '0;
      r_wy_min    <= RowLast;
      r_wy_max    <= '0;
      r_whits     <= '0;
      r_x_min     <= '0;
      r_x_max     <= '0;
      r_y_min     <= '0;
      r_y_max     <= '0;
      r_hit_cnt   <= '0;
      r_box_valid <= 1'b0;
      r_po_flag   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_col       <= w_col_nxt;
      r_row       <= w_row_nxt;
      r_wx_min    <= w_wx_min_nxt;
      r_wx_max    <= w_wx_max_nxt;
      r_wy_min    <= w_wy_min_nxt;
      r_wy_max    <= w_wy_max_nxt;
      r_whits     <= w_whits_nxt;
      r_x_min     <= w_x_min_nxt;
      r_x_max     <= w_x_max_nxt;
      r_y_min     <= w_y_min_nxt;
      r_y_max     <= w_y_max_nxt;
      r_hit_cnt   <= w_hit_cnt_nxt;
      r_box_valid <= w_box_valid_nxt;
      r_po_flag   <= w_po_flag_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  assign x_min     = r_x_min;
  assign x_max     = r_x_max;
  assign y_min     = r_y_min;
  assign y_max     = r_y_max;
  assign hit_cnt   = r_hit_cnt;
  assign box_valid = r_box_valid;
  assign po_flag   = r_po_flag;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_bbox_seek.sv
// Bench for bbox_seek on an 8x4 frame: random frames scored against a whole-frame
// reference computed from the pixel array, plus directed sync-error and reset scenarios.
module tb_bbox_seek;
  localparam int unsigned W = 8, H = 4, DW = 8, TH = 10, MH = 2, CW = 4, HW = 6;
  localparam int unsigned N = W * H;
  localparam int unsigned RW = 4 * CW + HW + 1;

  logic          sclk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] pi_data = '0;
  logic          pi_flag = 1'b0;
  logic          pi_sof = 1'b0;
  logic [CW-1:0] x_min, x_max, y_min, y_max;
  logic [HW-1:0] hit_cnt;
  logic          box_valid, po_flag, frame_err;
  logic [RW-1:0] got;

  int n_cmp = 0, n_bad = 0, po_cnt = 0, err_cnt = 0;
  int unsigned g_pix[N];

  bbox_seek #(
    .IMG_W(W), .IMG_H(H), .DATA_W(DW), .THRESH(TH), .MIN_HITS(MH), .CNT_W(CW), .HIT_W(HW)
  ) u_dut (
    .sclk(sclk), .rst_n(rst_n), .pi_data(pi_data), .pi_flag(pi_flag), .pi_sof(pi_sof),
    .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max), .hit_cnt(hit_cnt),
    .box_valid(box_valid), .po_flag(po_flag), .frame_err(frame_err)
  );

  always #5 sclk = ~sclk;
  assign got = {x_min, x_max, y_min, y_max, hit_cnt, box_valid};

  always @(negedge sclk) begin
    if (po_flag) po_cnt++;
    if (frame_err) err_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
    $fatal(1);
  end

  // Whole-frame reference: scan the pixel array, derive box and verdict directly.
  function automatic logic [RW-1:0] model();
    int unsigned hits, xl, xh, yl, yh, c, r;
    hits = 0; xl = W - 1; xh = 0; yl = H - 1; yh = 0;
    for (int i = 0; i < int'(N); i++) begin
      c = i % W;
      r = i / W;
      if (g_pix[i] > TH) begin
        hits++;
        if (c < xl) xl = c;
        if (c > xh) xh = c;
        if (r < yl) yl = r;
        if (r > yh) yh = r;
      end
    end
    if (hits >= MH) return {CW'(xl), CW'(xh), CW'(yl), CW'(yh), HW'(hits), 1'b1};
    return {{(4 * CW){1'b0}}, HW'(hits), 1'b0};
  endfunction

  task automatic fill(input int unsigned pct);
    for (int i = 0; i < int'(N); i++)
      g_pix[i] = ($urandom_range(0, 99) < pct) ? $urandom_range(TH + 1, 255) : $urandom_range(0, TH);
  endtask

  task automatic drive_pix(input int unsigned d, input bit sof);
    pi_flag = 1'b1;
    pi_data = DW'(d);
    pi_sof  = sof;
    @(posedge sclk); #1;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      pi_flag = 1'b0;
      pi_sof  = 1'($urandom_range(0, 1));
      pi_data = DW'($urandom);
      @(posedge sclk); #1;
    end
    pi_sof = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi, input int unsigned gmax);
    for (int i = lo; i <= hi; i++) begin
      idle($urandom_range(0, gmax));
      drive_pix(g_pix[i], i == 0);
    end
    pi_flag = 1'b0;
    pi_sof  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    n_cmp++;
    if (got !== '0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", got); end
    n_cmp++;
    if ({po_flag, frame_err} !== 2'b00) begin
      n_bad++; $display("FAIL reset_pulses: got %b want 00", {po_flag, frame_err});
    end
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_basic();
    for (int i = 0; i < int'(N); i++) g_pix[i] = 0;
    g_pix[1 * W + 2] = 50;
    g_pix[3 * W + 5] = 50;
    send_range(0, N - 1, 0);
    n_cmp++;
    if (po_flag !== 1'b1) begin n_bad++; $display("FAIL basic_po: got %b want 1", po_flag); end
    n_cmp++;
    if (got !== {4'd2, 4'd5, 4'd1, 4'd3, 6'd2, 1'b1}) begin
      n_bad++; $display("FAIL basic_result: got %h want %h", got, {4'd2, 4'd5, 4'd1, 4'd3, 6'd2, 1'b1});
    end
    idle(1);
    n_cmp++;
    if (po_flag !== 1'b0) begin n_bad++; $display("FAIL basic_po_width: got %b want 0", po_flag); end
  endtask

  task automatic test_threshold();
    for (int i = 0; i < int'(N); i++) g_pix[i] = 0;
    g_pix[6] = 50;
    g_pix[9] = TH;
    g_pix[20] = TH;
    g_pix[N - 1] = TH;
    send_range(0, N - 1, 0);
    n_cmp++;
    if (got !== {16'd0, 6'd1, 1'b0}) begin
      n_bad++; $display("FAIL threshold_result: got %h want %h", got, {16'd0, 6'd1, 1'b0});
    end
  endtask

  task automatic test_ignore_pre_sof();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) drive_pix(50, 1'b0);
    pi_flag = 1'b0;
    fill(30);
    send_range(0, N - 1, 0);
    n_cmp++;
    if (po_flag !== 1'b1) begin n_bad++; $display("FAIL ignore_po: got %b want 1", po_flag); end
    n_cmp++;
    if (got !== model()) begin n_bad++; $display("FAIL ignore_result: got %h want %h", got, model()); end
  endtask

  task automatic test_random_frames();
    for (int k = 0; k < 6; k++) begin
      fill($urandom_range(0, 40));
      send_range(0, N - 1, 0);
      n_cmp++;
      if ({po_flag, got} !== {1'b1, model()}) begin
        n_bad++; $display("FAIL random_frame%0d: got %b/%h want 1/%h", k, po_flag, got, model());
      end
    end
  endtask

  task automatic test_premature_sof(input int at);
    logic [RW-1:0] prev;
    int e0, p0;
    prev = model();
    fill(35);
    send_range(0, at - 1, 1);
    n_cmp++;
    if (got !== prev) begin n_bad++; $display("FAIL held_midframe: got %h want %h", got, prev); end
    e0 = err_cnt; p0 = po_cnt;
    fill(35);
    drive_pix(g_pix[0], 1'b1);
    n_cmp++;
    if ({frame_err, po_flag} !== 2'b10) begin
      n_bad++; $display("FAIL premature_pulse@%0d: got err/po %b want 10", at, {frame_err, po_flag});
    end
    n_cmp++;
    if (got !== prev) begin n_bad++; $display("FAIL premature_held@%0d: got %h want %h", at, got, prev); end
    send_range(1, N - 1, 0);
    n_cmp++;
    if ({po_flag, got} !== {1'b1, model()}) begin
      n_bad++; $display("FAIL premature_next@%0d: got %b/%h want 1/%h", at, po_flag, got, model());
    end
    idle(1);
    n_cmp++;
    if ((err_cnt - e0) != 1 || (po_cnt - p0) != 1) begin
      n_bad++; $display("FAIL premature_counts@%0d: got err %0d po %0d want 1 1", at, err_cnt - e0, po_cnt - p0);
    end
  endtask

  task automatic test_gaps();
    logic [RW-1:0] exp;
    int p0;
    fill(30);
    exp = model();
    send_range(0, N - 1, 0);
    n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL gapless_ref: got %h want %h", got, exp); end
    idle(2);
    p0 = po_cnt;
    send_range(0, N - 2, 3);
    n_cmp++;
    if (po_cnt != p0 || po_flag !== 1'b0) begin
      n_bad++; $display("FAIL gaps_early_po: got %0d pulses want 0", po_cnt - p0 + int'(po_flag));
    end
    send_range(N - 1, N - 1, 3);
    n_cmp++;
    if ({po_flag, got} !== {1'b1, exp}) begin
      n_bad++; $display("FAIL gaps_result: got %b/%h want 1/%h", po_flag, got, exp);
    end
    idle(3);
    n_cmp++;
    if (po_cnt - p0 != 1) begin n_bad++; $display("FAIL gaps_po_count: got %0d want 1", po_cnt - p0); end
  endtask

  task automatic test_reset_midframe();
    int p0, e0;
    for (int i = 0; i < int'(N); i++) g_pix[i] = 50;
    p0 = po_cnt; e0 = err_cnt;
    send_range(0, 19, 0);
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({got, po_flag, frame_err} !== '0) begin
      n_bad++; $display("FAIL midreset_outputs: got %h/%b%b want 0", got, po_flag, frame_err);
    end
    @(posedge sclk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < int'(N); i++) g_pix[i] = 0;
    g_pix[1 * W + 3] = 99;
    g_pix[2 * W + 4] = 99;
    g_pix[1 * W + 5] = 99;
    send_range(0, N - 1, 0);
    n_cmp++;
    if (got !== {4'd3, 4'd5, 4'd1, 4'd2, 6'd3, 1'b1}) begin
      n_bad++; $display("FAIL midreset_next: got %h want %h", got, {4'd3, 4'd5, 4'd1, 4'd2, 6'd3, 1'b1});
    end
    idle(1);
    n_cmp++;
    if (po_cnt - p0 != 1 || err_cnt != e0) begin
      n_bad++; $display("FAIL midreset_counts: got po %0d err %0d want 1 0", po_cnt - p0, err_cnt - e0);
    end
  endtask

  task automatic test_back_to_back();
    logic [RW-1:0] exp_a;
    fill(25);
    exp_a = model();
    send_range(0, N - 1, 0);
    n_cmp++;
    if ({po_flag, got} !== {1'b1, exp_a}) begin
      n_bad++; $display("FAIL b2b_first: got %b/%h want 1/%h", po_flag, got, exp_a);
    end
    fill(25);
    send_range(0, N - 1, 0);
    n_cmp++;
    if ({po_flag, got} !== {1'b1, model()}) begin
      n_bad++; $display("FAIL b2b_second: got %b/%h want 1/%h", po_flag, got, model());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_threshold();
    test_ignore_pre_sof();
    test_random_frames();
    test_premature_sof(13);
    test_premature_sof(N - 1);
    test_gaps();
    test_reset_midframe();
    test_back_to_back();
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
